// File: rtl/demux_1to2_reg.sv
// demux_1to2_reg
//   Registered 1-to-2 demultiplexer. One input stream is steered, per transfer,
//   to one of two output ports by in_sel. Each output port has a one-entry
//   holding register with a valid/ready handshake and a counter of completed
//   output handshakes, so the two consumers can stall independently.
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   rst              synchronous, active-high reset
//   in_data          input payload (WIDTH)
//   in_sel           destination select: 0 -> port 0, 1 -> port 1
//   in_valid         input payload valid
//   in_ready         block can accept input this cycle (combinational)
//   outX_data        port X payload (WIDTH), last value kept while empty
//   outX_valid       port X holding register occupied
//   outX_ready       port X consumer accepts
//   cntX             completed port X output handshakes (CNT_W, wraps)
module demux_1to2_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic slot0_free;
    logic slot1_free;
    logic accept;
    logic accept0;
    logic accept1;
    logic drain0;
    logic drain1;

    // A slot can take new data when empty, or when it drains at this same edge.
    // The outX_ready -> in_ready path is deliberately combinational so a
    // streaming port sustains one transfer per cycle.
    assign slot0_free = !out0_valid || out0_ready;
    assign slot1_free = !out1_valid || out1_ready;
    assign in_ready   = !rst && (in_sel ? slot1_free : slot0_free);

    assign accept  = in_valid && in_ready;
    assign accept0 = accept && !in_sel;
    assign accept1 = accept && in_sel;
    assign drain0  = out0_valid && out0_ready;
    assign drain1  = out1_valid && out1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_data  <= '0;
            out0_valid <= 1'b0;
            out1_data  <= '0;
            out1_valid <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            // Port 0: a refill at the drain edge keeps the slot full.
            if (accept0) begin
                out0_data  <= in_data;
                out0_valid <= 1'b1;
            end else if (drain0) begin
                out0_valid <= 1'b0;
            end
            if (drain0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end

            // Port 1
            if (accept1) begin
                out1_data  <= in_data;
                out1_valid <= 1'b1;
            end else if (drain1) begin
                out1_valid <= 1'b0;
            end
            if (drain1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_1to2_reg.sv
module tb_demux_1to2_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int vectors = 0;
    int errors  = 0;

    demux_1to2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
        out0_ready = 1'b0; out1_ready = 1'b0;
        step(); step();
        vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL rst_out0_valid got %b want 0", out0_valid); end
        vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_out1_valid got %b want 0", out1_valid); end
        vectors++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL rst_cnt0 got %0d want 0", cnt0); end
        vectors++; if (cnt1 !== 4'd0) begin errors++; $display("FAIL rst_cnt1 got %0d want 0", cnt1); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++; if (out0_data !== 32'h0) begin errors++; $display("FAIL rst_out0_data got %h want 0", out0_data); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_routing();
        do_reset();
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5_0001;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready got %b want 1", in_ready); end
        step();
        vectors++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL route_out0_valid got %b want 1", out0_valid); end
        vectors++; if (out0_data !== 32'hA5A5_0001) begin errors++; $display("FAIL route_out0_data got %h want a5a50001", out0_data); end
        vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_idle got %b want 0", out1_valid); end
        in_sel = 1'b1; in_data = 32'h5A5A_0002;
        step();
        vectors++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL route_out1_valid got %b want 1", out1_valid); end
        vectors++; if (out1_data !== 32'h5A5A_0002) begin errors++; $display("FAIL route_out1_data got %h want 5a5a0002", out1_data); end
        vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL route_out0_drained got %b want 0", out0_valid); end
        vectors++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL route_cnt0 got %0d want 1", cnt0); end
        in_valid = 1'b0;
        step();
        vectors++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL route_cnt1 got %0d want 1", cnt1); end
        vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route_out1_drained got %b want 0", out1_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h11;
        step();
        in_data = 32'h22;
        #1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
        step();
        vectors++; if (out0_data !== 32'h11) begin errors++; $display("FAIL bp_hold_data got %h want 11", out0_data); end
        vectors++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", out0_valid); end
        vectors++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL bp_cnt0_stalled got %0d want 0", cnt0); end
        out0_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_comb got %b want 1", in_ready); end
        step();
        vectors++; if (out0_data !== 32'h22) begin errors++; $display("FAIL bp_refill_data got %h want 22", out0_data); end
        vectors++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL bp_refill_valid got %b want 1", out0_valid); end
        vectors++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL bp_cnt0_first got %0d want 1", cnt0); end
        in_valid = 1'b0;
        step();
        vectors++; if (cnt0 !== 4'd2) begin errors++; $display("FAIL bp_cnt0_second got %0d want 2", cnt0); end
        vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out0_valid); end
    endtask

    task automatic test_independence();
        do_reset();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h44;
        step();
        in_sel = 1'b1; in_data = 32'h33;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_in_ready got %b want 1", in_ready); end
        step();
        vectors++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL ind_out1_valid got %b want 1", out1_valid); end
        vectors++; if (out1_data !== 32'h33) begin errors++; $display("FAIL ind_out1_data got %h want 33", out1_data); end
        vectors++; if (out0_data !== 32'h44) begin errors++; $display("FAIL ind_out0_data got %h want 44", out0_data); end
        in_valid = 1'b0;
        step();
        vectors++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL ind_cnt1 got %0d want 1", cnt1); end
        vectors++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL ind_out0_held got %b want 1", out0_valid); end
        vectors++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL ind_cnt0 got %0d want 0", cnt0); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] word;
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        out0_ready = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            word = 32'h1000 + WIDTH'(i);
            in_data = word;
            #1;
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
            step();
            // word i lands now; words 0..i-1 have drained
            exp_cnt = CNT_W'(i);
            vectors++; if (out0_data !== word || out0_valid !== 1'b1) begin errors++; $display("FAIL b2b_data[%0d] got %h/%b want %h/1", i, out0_data, out0_valid, word); end
            vectors++; if (cnt0 !== exp_cnt) begin errors++; $display("FAIL b2b_cnt0[%0d] got %0d want %0d", i, cnt0, exp_cnt); end
        end
        in_valid = 1'b0;
        step();
        vectors++; if (cnt0 !== 4'd4) begin errors++; $display("FAIL b2b_cnt0_wrap got %0d want 4", cnt0); end
        vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out0_valid); end
    endtask

    task automatic test_mid_reset();
        // counters still hold 4 from the streaming test
        out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55;
        step();
        in_sel = 1'b1; in_data = 32'h66;
        step();
        vectors++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1) begin errors++; $display("FAIL mr_both_full got %b%b want 11", out0_valid, out1_valid); end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL mr_valids got %b%b want 00", out0_valid, out1_valid); end
        vectors++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin errors++; $display("FAIL mr_counts got %0d/%0d want 0/0", cnt0, cnt1); end
        vectors++; if (out0_data !== 32'h0 || out1_data !== 32'h0) begin errors++; $display("FAIL mr_data got %h/%h want 0/0", out0_data, out1_data); end
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL mr_stale_valid[%0d] got %b%b want 00", i, out0_valid, out1_valid); end
            vectors++; if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin errors++; $display("FAIL mr_stale_cnt[%0d] got %0d/%0d want 0/0", i, cnt0, cnt1); end
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
